// File: rtl/tod_tx_sched.sv
// Per-second ToD frame scheduler: snapshots ToD fields on each PPS edge and, after
// TX_DELAY_CYC cycles, streams a 14-byte checksummed frame over valid/ready.
// Optional macro TOD_TX_SEC_INC_EN: frame announces the next second (week rollover aware).
module tod_tx_sched #(
  parameter int unsigned TX_DELAY_CYC = 125_000,
  parameter logic [7:0]  HDR0         = 8'h43,
  parameter logic [7:0]  HDR1         = 8'h4D,
  parameter logic [7:0]  MSG_TYPE     = 8'h01
) (
  input  logic        clk_125m,
  input  logic        rst,
  input  logic        pps,
  input  logic        enable,
  input  logic [15:0] week,
  input  logic [31:0] week_sec,
  input  logic [7:0]  leap_sec,
  input  logic [7:0]  pps_state,
  input  logic [7:0]  timesrc_type,
  input  logic [7:0]  pps_precision,
  output logic [7:0]  tx_data,
  output logic        tx_vld,
  input  logic        tx_rdy,
  output logic        busy,
  output logic        frame_done,
  output logic [7:0]  overrun_cnt
);
  localparam int unsigned    CW       = (TX_DELAY_CYC > 1) ? $clog2(TX_DELAY_CYC) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(TX_DELAY_CYC - 1);
  localparam logic [3:0]     IDX_LAST = 4'd13;

  typedef enum logic [1:0] {IDLE, WAIT, SEND} state_t;

  state_t        state_q, state_d;
  logic          pps_d_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]    idx_q, idx_d;
  logic [7:0]    csum_q, csum_d;
  logic [7:0]    tx_data_q, nxt_byte;
  logic          tx_vld_q;
  logic [7:0]    ovr_q;
  logic [15:0]   week_q;
  logic [31:0]   wsec_q;
  logic [7:0]    leap_q, pstate_q, tsrc_q, prec_q;

  logic pps_edge, start, wait_end, accept, last_acc;

  assign pps_edge = pps & ~pps_d_q;
  assign start    = (state_q == IDLE) & pps_edge & enable;
  assign wait_end = (state_q == WAIT) & (cnt_q == CNT_LAST);
  assign accept   = (state_q == SEND) & tx_vld_q & tx_rdy;
  assign last_acc = accept & (idx_q == IDX_LAST);

  always_ff @(posedge clk_125m or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)    state_d = WAIT;
      WAIT:    if (wait_end) state_d = SEND;
      SEND:    if (last_acc) state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  // Running checksum covers bytes 2..12; the mux picks the byte following the one just accepted.
  always_comb begin
    busy       = (state_q != IDLE);
    frame_done = last_acc;
    idx_d      = idx_q + 4'd1;
    csum_d     = csum_q + ((idx_q >= 4'd2) ? tx_data_q : 8'h00);
    case (idx_d)
      4'd1:    nxt_byte = HDR1;
      4'd2:    nxt_byte = MSG_TYPE;
      4'd3:    nxt_byte = week_q[15:8];
      4'd4:    nxt_byte = week_q[7:0];
      4'd5:    nxt_byte = wsec_q[31:24];
      4'd6:    nxt_byte = wsec_q[23:16];
      4'd7:    nxt_byte = wsec_q[15:8];
      4'd8:    nxt_byte = wsec_q[7:0];
      4'd9:    nxt_byte = leap_q;
      4'd10:   nxt_byte = pstate_q;
      4'd11:   nxt_byte = tsrc_q;
      4'd12:   nxt_byte = prec_q;
      4'd13:   nxt_byte = csum_d;
      default: nxt_byte = HDR0;
    endcase
  end

  always_ff @(posedge clk_125m or posedge rst) begin
    if (rst) begin
      pps_d_q   <= 1'b0;
      cnt_q     <= '0;
      idx_q     <= '0;
      csum_q    <= '0;
      tx_data_q <= '0;
      tx_vld_q  <= 1'b0;
      ovr_q     <= '0;
      week_q    <= '0;
      wsec_q    <= '0;
      leap_q    <= '0;
      pstate_q  <= '0;
      tsrc_q    <= '0;
      prec_q    <= '0;
    end else begin
      pps_d_q <= pps;
      if (pps_edge && (state_q != IDLE) && (ovr_q != 8'hFF)) ovr_q <= ovr_q + 8'd1;
      case (state_q)
        IDLE: if (start) begin
          week_q   <= week;
          wsec_q   <= week_sec;
          leap_q   <= leap_sec;
          pstate_q <= pps_state;
          tsrc_q   <= timesrc_type;
          prec_q   <= pps_precision;
          cnt_q    <= '0;
        end
        WAIT: begin
          cnt_q <= cnt_q + 1'b1;
`ifdef TOD_TX_SEC_INC_EN
          // Done once on the first WAIT cycle; header byte 0 never depends on it.
          if (cnt_q == '0) begin
            if (wsec_q == 32'd604_799) begin
              wsec_q <= '0;
              week_q <= week_q + 16'd1;
            end else begin
              wsec_q <= wsec_q + 32'd1;
            end
          end
`endif
          if (wait_end) begin
            idx_q     <= '0;
            csum_q    <= '0;
            tx_vld_q  <= 1'b1;
            tx_data_q <= HDR0;
          end
        end
        SEND: if (accept) begin
          if (idx_q == IDX_LAST) begin
            tx_vld_q <= 1'b0;
          end else begin
            idx_q     <= idx_d;
            csum_q    <= csum_d;
            tx_data_q <= nxt_byte;
          end
        end
        default: ;
      endcase
    end
  end

  assign tx_data     = tx_data_q;
  assign tx_vld      = tx_vld_q;
  assign overrun_cnt = ovr_q;
endmodule

// File: tb/tb_tod_tx_sched.sv
// Bench for tod_tx_sched: directed scenarios plus randomized traffic against a
// frame-queue reference model compared on every clock.
module tb_tod_tx_sched;
  localparam int DLY = 10;

  logic        clk_125m = 1'b0, rst = 1'b1, pps = 1'b0, enable = 1'b0, tx_rdy = 1'b1;
  logic [15:0] week = '0;
  logic [31:0] week_sec = '0;
  logic [7:0]  leap_sec = '0, pps_state = '0, timesrc_type = '0, pps_precision = '0;
  logic [7:0]  tx_data, overrun_cnt;
  logic        tx_vld, busy, frame_done;

  tod_tx_sched #(.TX_DELAY_CYC(DLY)) dut (
    .clk_125m(clk_125m), .rst(rst), .pps(pps), .enable(enable),
    .week(week), .week_sec(week_sec), .leap_sec(leap_sec), .pps_state(pps_state),
    .timesrc_type(timesrc_type), .pps_precision(pps_precision),
    .tx_data(tx_data), .tx_vld(tx_vld), .tx_rdy(tx_rdy), .busy(busy),
    .frame_done(frame_done), .overrun_cnt(overrun_cnt));

  always #4 clk_125m = ~clk_125m;

  int checks = 0, failures = 0, cyc = 0, rdy_mode = 0;
  typedef logic [13:0][7:0] frame_t;
  typedef logic [7:0] bytes_t [14];

  always @(posedge clk_125m) cyc <= cyc + 1;

  always @(posedge clk_125m) begin
    #1;
    case (rdy_mode)
      0:       tx_rdy = 1'b1;
      1:       tx_rdy = (cyc % 3 == 0);
      default: tx_rdy = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Frame content straight from the byte-order table.
  function automatic frame_t build(input logic [15:0] w, input logic [31:0] s,
                                   input logic [7:0] l, input logic [7:0] p,
                                   input logic [7:0] t, input logic [7:0] pr);
    frame_t f;
    logic [7:0] sum;
    sum = 8'h00;
`ifdef TOD_TX_SEC_INC_EN
    if (s == 32'd604799) begin s = 0; w = w + 16'd1; end
    else s = s + 32'd1;
`endif
    f[0] = 8'h43; f[1] = 8'h4D; f[2] = 8'h01;
    f[3] = w[15:8]; f[4] = w[7:0];
    f[5] = s[31:24]; f[6] = s[23:16]; f[7] = s[15:8]; f[8] = s[7:0];
    f[9] = l; f[10] = p; f[11] = t; f[12] = pr;
    for (int i = 2; i <= 12; i++) sum = sum + f[i];
    f[13] = sum;
    return f;
  endfunction

  // Reference model: pending-byte queue plus a countdown before the first byte.
  logic [7:0] m_q[$];
  int   m_wait = 0, m_ovr = 0;
  logic m_prev = 1'b0;
  always @(negedge clk_125m) begin : mdl
    bit m_busy, m_vld, m_done;
    frame_t f;
    if (rst) begin
      m_q.delete(); m_wait = 0; m_ovr = 0; m_prev = 1'b0;
    end else begin
      m_busy = (m_wait > 0) || (m_q.size() > 0);
      m_vld  = (m_wait == 0) && (m_q.size() > 0);
      m_done = m_vld && tx_rdy && (m_q.size() == 1);
      chk("busy", 64'(busy), 64'(m_busy));
      chk("tx_vld", 64'(tx_vld), 64'(m_vld));
      if (m_vld) chk("tx_data", 64'(tx_data), 64'(m_q[0]));
      chk("frame_done", 64'(frame_done), 64'(m_done));
      chk("overrun_cnt", 64'(overrun_cnt), 64'(m_ovr));
      if (m_wait > 0) m_wait--;
      else if (m_vld && tx_rdy) void'(m_q.pop_front());
      if (pps && !m_prev) begin
        if (m_busy) begin
          if (m_ovr < 255) m_ovr++;
        end else if (enable) begin
          f = build(week, week_sec, leap_sec, pps_state, timesrc_type, pps_precision);
          for (int i = 0; i < 14; i++) m_q.push_back(f[i]);
          m_wait = DLY;
        end
      end
      m_prev = pps;
    end
  end

  logic [7:0] cap[$];
  always @(negedge clk_125m) if (!rst && tx_vld && tx_rdy) cap.push_back(tx_data);

  task automatic pulse();
    @(posedge clk_125m); #1 pps = 1'b1;
    @(posedge clk_125m); #1 pps = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    do begin @(negedge clk_125m); n++; end while (!frame_done && n < 500);
    chk("frame_done_timeout", 64'(frame_done), 64'd1);
    #1;
  endtask

  task automatic wait_vld();
    int n = 0;
    do begin @(negedge clk_125m); n++; end while (!tx_vld && n < 100);
    chk("tx_vld_timeout", 64'(tx_vld), 64'd1);
  endtask

  task automatic chk_frame(input string nm, input bytes_t e);
    frame_t mf;
    mf = build(week, week_sec, leap_sec, pps_state, timesrc_type, pps_precision);
    chk({nm, "_len"}, 64'(cap.size()), 64'd14);
    for (int i = 0; i < 14; i++) begin
      chk({nm, "_model"}, 64'(mf[i]), 64'(e[i]));
      if (i < cap.size()) chk({nm, "_byte"}, 64'(cap[i]), 64'(e[i]));
    end
  endtask

  task automatic set_basic();
    week = 16'h0901; week_sec = 32'h0001_E240; leap_sec = 8'd18;
    pps_state = 8'd1; timesrc_type = 8'd2; pps_precision = 8'd3;
  endtask

`ifdef TOD_TX_SEC_INC_EN
  bytes_t exp_basic = '{8'h43, 8'h4D, 8'h01, 8'h09, 8'h01, 8'h00, 8'h01, 8'hE2, 8'h41,
                        8'h12, 8'h01, 8'h02, 8'h03, 8'h47};
  bytes_t exp_roll  = '{8'h43, 8'h4D, 8'h01, 8'h00, 8'h65, 8'h00, 8'h00, 8'h00, 8'h00,
                        8'h12, 8'h01, 8'h02, 8'h03, 8'h7E};
`else
  bytes_t exp_basic = '{8'h43, 8'h4D, 8'h01, 8'h09, 8'h01, 8'h00, 8'h01, 8'hE2, 8'h40,
                        8'h12, 8'h01, 8'h02, 8'h03, 8'h46};
  bytes_t exp_roll  = '{8'h43, 8'h4D, 8'h01, 8'h00, 8'h64, 8'h00, 8'h09, 8'h3A, 8'h7F,
                        8'h12, 8'h01, 8'h02, 8'h03, 8'h3F};
`endif

  initial begin
    int e_cyc;
    repeat (3) @(posedge clk_125m);
    #1;
    chk("rst_tx_vld", 64'(tx_vld), 64'd0);
    chk("rst_tx_data", 64'(tx_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    chk("rst_overrun", 64'(overrun_cnt), 64'd0);
    rst = 1'b0;
    set_basic();
    enable = 1'b1;

    // Basic frame and first-byte latency
    cap.delete();
    @(posedge clk_125m); #1 pps = 1'b1; e_cyc = cyc;
    @(posedge clk_125m); #1 pps = 1'b0;
    wait_vld();
    chk("first_vld_cycle", 64'(cyc), 64'(e_cyc + DLY + 1));
    wait_done();
    chk_frame("basic", exp_basic);

    // Backpressure
    rdy_mode = 1;
    cap.delete();
    pulse();
    wait_done();
    chk_frame("bp", exp_basic);
    rdy_mode = 0;

    // Overrun 5 cycles after E, then an edge right after frame_done
    cap.delete();
    pulse();
    repeat (3) @(posedge clk_125m);
    pulse();
    wait_done();
    chk("ovr_one", 64'(overrun_cnt), 64'd1);
    chk_frame("ovr", exp_basic);
    cap.delete();
    pulse();
    wait_done();
    chk_frame("post_done", exp_basic);
    chk("ovr_still_one", 64'(overrun_cnt), 64'd1);

    // Enable gating and enable drop mid-frame
    enable = 1'b0;
    pulse();
    repeat (20) @(negedge clk_125m);
    chk("dis_busy", 64'(busy), 64'd0);
    chk("dis_ovr", 64'(overrun_cnt), 64'd1);
    enable = 1'b1;
    cap.delete();
    pulse();
    wait_vld();
    repeat (3) @(posedge clk_125m);
    #1 enable = 1'b0;
    wait_done();
    chk_frame("en_drop", exp_basic);
    enable = 1'b1;

    // Reset while byte 6 is offered
    cap.delete();
    pulse();
    wait_vld();
    repeat (6) @(negedge clk_125m);
    #2 rst = 1'b1;
    #1;
    chk("midrst_tx_vld", 64'(tx_vld), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    repeat (2) @(posedge clk_125m);
    #1 rst = 1'b0;
    chk("midrst_ovr", 64'(overrun_cnt), 64'd0);
    cap.delete();
    pulse();
    wait_done();
    chk_frame("after_rst", exp_basic);

    // Week-end boundary
    week = 16'd100; week_sec = 32'd604799;
    cap.delete();
    pulse();
    wait_done();
    chk_frame("roll", exp_roll);

    // Randomized traffic; fields churn every cycle to exercise snapshot isolation
    rdy_mode = 2;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk_125m); #1;
      week = 16'($urandom); leap_sec = 8'($urandom);
      week_sec = ($urandom_range(0, 7) == 0) ? 32'd604799 : $urandom_range(0, 604799);
      pps_state = 8'($urandom); timesrc_type = 8'($urandom); pps_precision = 8'($urandom);
      enable = ($urandom_range(0, 3) != 0);
      pps = ($urandom_range(0, 29) == 0);
    end

    // Overrun saturation
    rdy_mode = 0;
    enable = 1'b1;
    for (int i = 0; i < 1200; i++) begin
      @(posedge clk_125m); #1 pps = ~pps;
    end
    pps = 1'b0;
    @(negedge clk_125m);
    chk("ovr_saturated", 64'(overrun_cnt), 64'd255);
    repeat (100) @(posedge clk_125m);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
